// File: rtl/gdp_host_if.sv
// Signal bundle between gdp_host, its system-side requester and the GDP datapath.
// master: the environment (requester plus datapath); slave: the gdp_host block itself.
interface gdp_host_if;
    logic       req;
    logic [7:0] n_in;
    logic       ready;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       mismatch;
    logic       timeout_err;
    logic       gdp_start_n;
    logic       gdp_restart_n;
    logic [7:0] gdp_n;
    logic [7:0] gdp_sum;
    logic       gdp_done;

    modport master (
        output req, n_in, gdp_sum, gdp_done,
        input  ready, busy, result, result_valid, mismatch, timeout_err,
        input  gdp_start_n, gdp_restart_n, gdp_n
    );

    modport slave (
        input  req, n_in, gdp_sum, gdp_done,
        output ready, busy, result, result_valid, mismatch, timeout_err,
        output gdp_start_n, gdp_restart_n, gdp_n
    );
endinterface

// File: rtl/gdp_host.sv
// Initiator for the GDP start/n -> Sum/done handshake: issues one request, captures
// and checks the returned Sum against n*(n+1)/2 mod 256, and recovers from a hung GDP.
//
// state     | meaning
// S_INIT    | GDP restart pulse after reset release
// S_IDLE    | ready, waiting for req
// S_START   | gdp_start_n low for START_CYC cycles
// S_WAIT    | waiting for gdp_done, timeout timer running
// S_CAPTURE | sample gdp_sum, compare with expected
// S_RESTART | result_valid pulse, GDP restart pulse
// S_ERR     | timeout flagged, GDP restart pulse
module gdp_host #(
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic      clk,
    input  logic      restart,
    gdp_host_if.slave bus
);
    localparam int TMAX = (TIMEOUT > START_CYC) ? TIMEOUT : START_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESTART = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmr;
    logic [7:0]    expected;
    logic          accept;

    logic          start_n_q;
    logic          restart_n_q;
    logic [7:0]    gdp_n_q;
    logic          ready_q;
    logic          busy_q;
    logic [7:0]    result_q;
    logic          result_valid_q;
    logic          mismatch_q;
    logic          timeout_q;

    assign accept = (state == S_IDLE) && bus.req;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:    state_nxt = S_IDLE;
            S_IDLE:    if (bus.req) state_nxt = S_START;
            S_START:   if (tmr == '0) state_nxt = S_WAIT;
            S_WAIT: begin
                // done takes priority over an expiring timer
                if (bus.gdp_done)    state_nxt = S_CAPTURE;
                else if (tmr == '0)  state_nxt = S_ERR;
            end
            S_CAPTURE: state_nxt = S_RESTART;
            S_RESTART: state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_INIT;
        endcase
    end

    // All outputs are registered from the next state so the GDP strobes are glitch-free.
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state          <= S_INIT;
            tmr            <= '0;
            expected       <= '0;
            start_n_q      <= 1'b1;
            restart_n_q    <= 1'b0;
            gdp_n_q        <= '0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state          <= state_nxt;
            start_n_q      <= (state_nxt != S_START);
            restart_n_q    <= !(state_nxt inside {S_INIT, S_RESTART, S_ERR});
            ready_q        <= (state_nxt == S_IDLE);
            busy_q         <= !(state_nxt inside {S_INIT, S_IDLE});
            result_valid_q <= (state == S_CAPTURE);

            if (state != S_START && state_nxt == S_START)
                tmr <= TW'(START_CYC - 1);
            else if (state == S_START && state_nxt == S_WAIT)
                tmr <= TW'(TIMEOUT - 1);
            else if (tmr != '0)
                tmr <= tmr - TW'(1);

            if (accept) begin
                gdp_n_q   <= bus.n_in;
                expected  <= 8'(({8'd0, bus.n_in} * ({8'd0, bus.n_in} + 16'd1)) >> 1);
                timeout_q <= 1'b0;
            end else if (!(state_nxt inside {S_START, S_WAIT, S_CAPTURE})) begin
                gdp_n_q <= '0;
            end

            if (state == S_CAPTURE) begin
                result_q   <= bus.gdp_sum;
                mismatch_q <= (bus.gdp_sum != expected);
            end

            if (state == S_WAIT && state_nxt == S_ERR)
                timeout_q <= 1'b1;
        end
    end

    assign bus.gdp_start_n   = start_n_q;
    assign bus.gdp_restart_n = restart_n_q;
    assign bus.gdp_n         = gdp_n_q;
    assign bus.ready         = ready_q;
    assign bus.busy          = busy_q;
    assign bus.result        = result_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.mismatch      = mismatch_q;
    assign bus.timeout_err   = timeout_q;
endmodule
